// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
//   Shared definitions for the PLL lock supervisor:
//     - pll_sup_state_e : 3-bit FSM state encoding (also driven on the debug
//                         `state` output, so the encodings are fixed)
//     - DEF_*           : default cycle counts derived from the 74.25 MHz
//                         reference clock
//     - retry_inc()     : saturating increment for the retry counter
// -----------------------------------------------------------------------------
package pll_sup_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_sup_state_e;

  localparam int unsigned REF_CLK_HZ = 74_250_000;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  // 10 ms of reference clock: 74.25 MHz / 100 = 742500 cycles.
  localparam int unsigned DEF_LOCK_TIMEOUT  = REF_CLK_HZ / 100;
  localparam int unsigned DEF_STABLE_CYCLES = 4096;
  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_CNT_W         = 20;
  localparam int unsigned DEF_MAX_RETRIES   = 8;

  // Saturates at all-ones so a long run of timeouts never wraps back to 0.
  function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
    return (v == '1) ? v : v + RETRY_W'(1);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor_if
//   Groups the PLL-facing, core-facing and debug signals of the supervisor.
//   master : the environment (drives pll_locked / force_relock)
//   slave  : the supervisor  (drives everything else)
//
//   Signal summary
//     pll_locked    PLL locked flag, asynchronous to the reference clock
//     force_relock  single-cycle restart request
//     pll_rst       active-high reset to the PLL
//     core_reset_n  active-low reset for PLL-clocked logic
//     lock_lost     one-cycle pulse when lock drops while running
//     retry_count   saturating count of lock timeouts since last RUN entry
//     state         encoded FSM state (debug)
//     fault         retry limit reached
//
//   Handshake: there is no valid/ready pair here. force_relock is a
//   fire-and-forget request: every cycle it is sampled high restarts the
//   sequence, with no acknowledge; the status outputs are level signals that
//   are valid every cycle, except lock_lost, which is a single-cycle event.
// -----------------------------------------------------------------------------
interface pll_lock_supervisor_if;
  import pll_sup_pkg::*;

  logic               pll_locked;
  logic               force_relock;
  logic               pll_rst;
  logic               core_reset_n;
  logic               lock_lost;
  logic [RETRY_W-1:0] retry_count;
  logic [STATE_W-1:0] state;
  logic               fault;

  modport master (
    output pll_locked,
    output force_relock,
    input  pll_rst,
    input  core_reset_n,
    input  lock_lost,
    input  retry_count,
    input  state,
    input  fault
  );

  modport slave (
    input  pll_locked,
    input  force_relock,
    output pll_rst,
    output core_reset_n,
    output lock_lost,
    output retry_count,
    output state,
    output fault
  );

endinterface

// File: rtl/pll_lock_supervisor_sync_bit.sv
// -----------------------------------------------------------------------------
// sync_bit
//   STAGES-deep flop chain bringing one asynchronous bit into the clk domain.
//   Ports:
//     clk    destination clock
//     rst_n  asynchronous active-low clear (all stages to 0)
//     d      asynchronous input
//     q      synchronised output, STAGES clk edges behind d
// -----------------------------------------------------------------------------
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//   Consumer-side controller for the core PLL. Runs on the free-running
//   reference clock: pulses the PLL reset, waits (with timeout) for lock,
//   qualifies the lock as stable, then releases the core reset. Loss of lock
//   while running re-asserts core reset and restarts the sequence.
//
//   Ports:
//     clk      reference clock (same net as the PLL refclk)
//     reset_n  asynchronous active-low reset
//     sup      pll_lock_supervisor_if.slave (pll_locked, force_relock in;
//              pll_rst, core_reset_n, lock_lost, retry_count, state, fault out)
//
//   Build option:
//     PLL_SUP_RETRY_LIMIT_EN  when defined, the MAX_RETRIES-th consecutive
//                             timeout parks the FSM in FAULT (PLL held in
//                             reset) until force_relock or reset_n. When
//                             undefined, retries go on forever and fault
//                             is tied low.
//
//   All decisions use the synchronised lock (lk); every output is registered
//   from the next-state logic so the outputs change on the same edge as the
//   state. One down-counter is shared by the timed states.
// -----------------------------------------------------------------------------
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pll_lock_supervisor_if.slave sup
);

  // ---------------------------------------------------------------------------
  // Configuration sanity: the counter must hold every load value and the
  // synchroniser needs at least two stages.
  // ---------------------------------------------------------------------------
  localparam longint unsigned CNT_CAP = 64'(1) << CNT_W;
  localparam bit CFG_OK = (SYNC_STAGES >= 2) &&
                          (RST_CYCLES >= 1) && (LOCK_TIMEOUT >= 1) &&
                          (STABLE_CYCLES >= 1) &&
                          (longint'(RST_CYCLES) < CNT_CAP) &&
                          (longint'(LOCK_TIMEOUT) < CNT_CAP) &&
                          (longint'(STABLE_CYCLES) < CNT_CAP) &&
                          (MAX_RETRIES >= 1) && (MAX_RETRIES <= 255);

  generate
    if (!CFG_OK) begin : g_cfg_error
      $error("pll_lock_supervisor: illegal parameter combination");
    end
  endgenerate

  // Counter reload values: a phase lasting N cycles loads N-1 and ends when
  // the counter is sampled at 0.
  localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

`ifdef PLL_SUP_RETRY_LIMIT_EN
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
`endif

  // ---------------------------------------------------------------------------
  // Lock synchroniser
  // ---------------------------------------------------------------------------
  logic lk;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (sup.pll_locked),
    .q     (lk)
  );

  // ---------------------------------------------------------------------------
  // FSM state, shared counter and registered outputs
  // ---------------------------------------------------------------------------
  pll_sup_state_e     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lock_lost_d;

  logic pll_rst_q;
  logic core_reset_n_q;
  logic lock_lost_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_RST_PLL;
      cnt_q          <= RST_LOAD;
      retry_q        <= '0;
      pll_rst_q      <= 1'b1;
      core_reset_n_q <= 1'b0;
      lock_lost_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      pll_rst_q      <= (state_d == ST_RST_PLL) || (state_d == ST_FAULT);
      core_reset_n_q <= (state_d == ST_RUN);
      lock_lost_q    <= lock_lost_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. force_relock is checked first so it overrides every
  // other transition, including a simultaneous loss of lock in RUN (which
  // therefore does not produce a lock_lost pulse).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q - CNT_ONE;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    if (sup.force_relock) begin
      state_d = ST_RST_PLL;
      cnt_d   = RST_LOAD;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RST_PLL: begin
          if (cnt_q == '0) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = TIMEOUT_LOAD;
          end
        end

        ST_WAIT_LOCK: begin
          // Lock seen on the timeout cycle still counts as a lock.
          if (lk) begin
            state_d = ST_STABLE;
            cnt_d   = STABLE_LOAD;
          end else if (cnt_q == '0) begin
            retry_d = retry_inc(retry_q);
            state_d = ST_RST_PLL;
            cnt_d   = RST_LOAD;
`ifdef PLL_SUP_RETRY_LIMIT_EN
            if (retry_d == RETRY_LIMIT) begin
              state_d = ST_FAULT;
            end
`endif
          end
        end

        ST_STABLE: begin
          // Any low cycle restarts the wait with a fresh timeout; this is
          // not a timeout, so retry_count is left alone.
          if (!lk) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = TIMEOUT_LOAD;
          end else if (cnt_q == '0) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end

        ST_RUN: begin
          cnt_d = cnt_q;
          if (!lk) begin
            state_d     = ST_RST_PLL;
            cnt_d       = RST_LOAD;
            lock_lost_d = 1'b1;
          end
        end

`ifdef PLL_SUP_RETRY_LIMIT_EN
        ST_FAULT: begin
          // Parked with the PLL held in reset; only force_relock or
          // reset_n leave this state.
          cnt_d = cnt_q;
        end
`endif

        default: begin
          state_d = ST_RST_PLL;
          cnt_d   = RST_LOAD;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sup.pll_rst      = pll_rst_q;
  assign sup.core_reset_n = core_reset_n_q;
  assign sup.lock_lost    = lock_lost_q;
  assign sup.retry_count  = retry_q;
  assign sup.state        = state_q;

`ifdef PLL_SUP_RETRY_LIMIT_EN
  logic fault_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= (state_d == ST_FAULT);
    end
  end

  assign sup.fault = fault_q;
`else
  assign sup.fault = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
//   Each scenario fills a per-edge stimulus table (pll_locked, force_relock),
//   a phase-level reference model turns that table into the list of output
//   changes it implies (edge number + full output tuple) and queues them.
//   The driver then replays the table while an independent monitor pops and
//   compares an entry every time the DUT output tuple changes.
//   Edge numbering: edge 1 is the first rising clk edge after reset_n rises;
//   the value driven for edge k is sampled by the first sync flop at edge k.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

  localparam int unsigned RST_C  = 4;
  localparam int unsigned TO_C   = 100;
  localparam int unsigned STAB_C = 10;
  localparam int unsigned SYNC_C = 2;
  localparam int unsigned MAXR_C = 3;

  localparam int MAXN = 800;
  localparam int W    = 47;   // 32-bit edge number + 15-bit output tuple

  // Model state numbering follows the published state encodings.
  localparam int M_RST    = 0;
  localparam int M_WAIT   = 1;
  localparam int M_STABLE = 2;
  localparam int M_RUN    = 3;
  localparam int M_FAULT  = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int edge_n;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_n <= 0;
    else          edge_n <= edge_n + 1;
  end

  pll_lock_supervisor_if sup ();

  pll_lock_supervisor #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (TO_C),
    .STABLE_CYCLES (STAB_C),
    .SYNC_STAGES   (SYNC_C),
    .CNT_W         (20),
    .MAX_RETRIES   (MAXR_C)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sup     (sup)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  string        cur_name = "init";

  bit lk_in [0:MAXN];
  bit fr    [0:MAXN];

  function automatic logic [14:0] outs(input int st, input int retry, input bit ll);
    logic [2:0] s;
    logic [7:0] r;
    s = 3'(st);
    r = 8'(retry);
    return {s, (st == M_RST || st == M_FAULT), (st == M_RUN), ll, r, (st == M_FAULT)};
  endfunction

  function automatic logic [14:0] dut_tuple();
    return {sup.state, sup.pll_rst, sup.core_reset_n, sup.lock_lost,
            sup.retry_count, sup.fault};
  endfunction

  function automatic string fmt(input logic [14:0] t);
    return $sformatf("state=%0d pll_rst=%0b core_reset_n=%0b lock_lost=%0b retry=%0d fault=%0b",
                     t[14:12], t[11], t[10], t[9], t[8:1], t[0]);
  endfunction

  // Synchronised lock as seen by the FSM at edge k (sync flops cleared by reset).
  function automatic bit lk_at(input int k);
    if (k - int'(SYNC_C) < 1) return 1'b0;
    return lk_in[k - int'(SYNC_C)];
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: tracks the current phase and the edge it was entered on;
  // phase lengths come straight from the cycle-count parameters.
  // ---------------------------------------------------------------------------
  task automatic build_expected(input int n);
    int st, e, retry;
    bit ll, l;
    logic [14:0] prev, cur;
    st = M_RST; e = 0; retry = 0;
    prev = outs(M_RST, 0, 1'b0);
    for (int k = 1; k <= n; k++) begin
      ll = 1'b0;
      l  = lk_at(k);
      if (fr[k]) begin
        st = M_RST; e = k; retry = 0;
      end else if (st == M_RST) begin
        if (k - e == int'(RST_C)) begin st = M_WAIT; e = k; end
      end else if (st == M_WAIT) begin
        if (l) begin
          st = M_STABLE; e = k;
        end else if (k - e == int'(TO_C)) begin
          if (retry < 255) retry++;
          st = M_RST; e = k;
`ifdef PLL_SUP_RETRY_LIMIT_EN
          if (retry == int'(MAXR_C)) st = M_FAULT;
`endif
        end
      end else if (st == M_STABLE) begin
        if (!l) begin
          st = M_WAIT; e = k;
        end else if (k - e == int'(STAB_C)) begin
          st = M_RUN; e = k; retry = 0;
        end
      end else if (st == M_RUN) begin
        if (!l) begin st = M_RST; e = k; ll = 1'b1; end
      end
      cur = outs(st, retry, ll);
      if (cur != prev) exp_q.push_back({32'(k), cur});
      prev = cur;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops one expectation per observed change of the output tuple.
  // ---------------------------------------------------------------------------
  initial begin
    logic [14:0]  prev_o, cur_o;
    logic [W-1:0] exp_w;
    prev_o = outs(M_RST, 0, 1'b0);
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_o = outs(M_RST, 0, 1'b0);
      end else begin
        cur_o = dut_tuple();
        if (cur_o != prev_o) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected_change: edge=%0d got %s, required no change",
                     cur_name, edge_n, fmt(cur_o));
          end else begin
            exp_w = exp_q.pop_front();
            if (exp_w != {32'(edge_n), cur_o}) begin
              errors++;
              $display("FAIL %s event: got edge=%0d %s, required edge=%0d %s",
                       cur_name, edge_n, fmt(cur_o), exp_w[46:15], fmt(exp_w[14:0]));
            end
          end
        end
        prev_o = cur_o;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic clear_stim();
    for (int k = 0; k <= MAXN; k++) begin
      lk_in[k] = 1'b0;
      fr[k]    = 1'b0;
    end
  endtask

  task automatic set_lock(input int from_k, input int to_k, input bit v);
    for (int k = from_k; k <= to_k && k <= MAXN; k++) lk_in[k] = v;
  endtask

  task automatic gen_random(input int n);
    int k, len;
    bit v;
    clear_stim();
    k = 1;
    v = 1'(($urandom_range(0, 1)));
    while (k <= n) begin
      len = v ? $urandom_range(5, 80) : $urandom_range(1, 30);
      for (int j = 0; j < len && k <= n; j++) begin
        lk_in[k] = v;
        k++;
      end
      v = ~v;
    end
    for (int j = 1; j <= n; j++) fr[j] = ($urandom_range(0, 199) == 0);
  endtask

  // Asserts reset asynchronously (between clock edges, often mid-sequence),
  // checks the reset values, then replays the stimulus table for n edges.
  task automatic run_scenario(input string name, input int n);
    logic [14:0] got;
    cur_name = name;
    reset_n = 1'b0;
    sup.pll_locked   = 1'b0;
    sup.force_relock = 1'b0;
    #1;
    got = dut_tuple();
    checks++;
    if (got != outs(M_RST, 0, 1'b0)) begin
      errors++;
      $display("FAIL %s reset_values: got %s, required %s",
               name, fmt(got), fmt(outs(M_RST, 0, 1'b0)));
    end
    build_expected(n);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= n; k++) begin
      sup.pll_locked   = lk_in[k];
      sup.force_relock = fr[k];
      @(negedge clk);
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending_events: got %0d unobserved, required 0 (next edge=%0d %s)",
               name, exp_q.size(), exp_q[0][46:15], fmt(exp_q[0][14:0]));
      exp_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    sup.pll_locked   = 1'b0;
    sup.force_relock = 1'b0;
    @(negedge clk);

    // Nominal: lock appears 20 cycles after reset release.
    clear_stim();
    set_lock(20, MAXN, 1'b1);
    run_scenario("nominal", 100);

    // Lock never comes: repeated timeouts, then a force_relock restart
    // (clears retry_count, and fault in the retry-limited build).
    clear_stim();
    fr[450] = 1'b1;
    run_scenario("timeout", 560);

    // Unstable lock: one low cycle in the middle of qualification.
    clear_stim();
    set_lock(20, MAXN, 1'b1);
    lk_in[27] = 1'b0;
    run_scenario("unstable", 100);

    // Loss of lock while running, then a later relock.
    clear_stim();
    set_lock(20, 59, 1'b1);
    set_lock(100, MAXN, 1'b1);
    run_scenario("loss_in_run", 150);

    // force_relock on the same edge lk falls in RUN: no lock_lost pulse.
    clear_stim();
    set_lock(20, 59, 1'b1);
    fr[62] = 1'b1;
    set_lock(70, MAXN, 1'b1);
    run_scenario("force_vs_loss", 120);

    // force_relock while qualifying and while waiting with retries pending.
    clear_stim();
    set_lock(250, MAXN, 1'b1);
    fr[160] = 1'b1;
    fr[255] = 1'b1;
    run_scenario("force_mid_seq", 320);

    // Randomised lock waveforms with sparse force_relock pulses.
    for (int i = 0; i < 6; i++) begin
      gen_random(500);
      run_scenario($sformatf("random%0d", i), 500);
    end

    reset_n = 1'b0;
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog: the stimulus is bounded, so this only trips if time stalls.
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
